// File: rtl/counter_ctrl.sv
// Run/stop/clear/mode control for a 0..MAX_COUNT up/down counter.
// Button pulses and UART command bytes are merged, prioritised and applied on a divided tick.
module counter_ctrl #(
    parameter int TICK_DIV  = 1_000_000,
    parameter int MAX_COUNT = 9999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_btn_run,
    input  logic        i_btn_clear,
    input  logic        i_btn_mode,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic [13:0] o_count,
    output logic        o_run,
    output logic        o_mode,
    output logic        o_tick
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
    localparam logic [13:0]      CNT_MAX  = 14'(MAX_COUNT);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_CLEAR} state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_div;
    logic [13:0]      r_count;
    logic             r_run;
    logic             r_mode;
    logic             r_tick;

    logic        w_rx_run, w_rx_clr, w_rx_mode;
    logic        w_run_cmd, w_clr_cmd, w_mode_cmd;
    logic [13:0] w_next_count;

    // A button and a UART byte for the same command in one cycle are OR-ed into one command.
    assign w_rx_run   = i_rx_valid && (i_rx_data == 8'h52 || i_rx_data == 8'h72);
    assign w_rx_clr   = i_rx_valid && (i_rx_data == 8'h43 || i_rx_data == 8'h63);
    assign w_rx_mode  = i_rx_valid && (i_rx_data == 8'h4D || i_rx_data == 8'h6D);
    assign w_run_cmd  = i_btn_run   || w_rx_run;
    assign w_clr_cmd  = i_btn_clear || w_rx_clr;
    assign w_mode_cmd = i_btn_mode  || w_rx_mode;

    always_comb begin
        w_next_count = r_count;
        if (!r_mode)
            w_next_count = (r_count == CNT_MAX) ? 14'd0 : r_count + 14'd1;
        else
            w_next_count = (r_count == 14'd0) ? CNT_MAX : r_count - 14'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_STOP;
            r_div   <= '0;
            r_count <= '0;
            r_run   <= 1'b0;
            r_mode  <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_state <= ST_STOP;
                r_div   <= '0;
                r_count <= '0;
                r_run   <= 1'b0;
            end else if (w_clr_cmd) begin
                r_state <= ST_CLEAR;
                r_div   <= '0;
                r_count <= '0;
                r_run   <= 1'b0;
            end else if (w_run_cmd) begin
                // Toggling run/stop freezes the divider, so a stop on a wrap cycle holds at DIV_LAST.
                r_state <= (r_state == ST_RUN) ? ST_STOP : ST_RUN;
                r_run   <= (r_state != ST_RUN);
            end else begin
                if (w_mode_cmd)
                    r_mode <= ~r_mode;
                if (r_state == ST_RUN) begin
                    if (r_div == DIV_LAST) begin
                        r_div   <= '0;
                        r_tick  <= 1'b1;
                        r_count <= w_next_count;
                    end else begin
                        r_div <= r_div + DIV_W'(1);
                    end
                end
            end
        end
    end

    assign o_count = r_count;
    assign o_run   = r_run;
    assign o_mode  = r_mode;
    assign o_tick  = r_tick;

endmodule

// File: tb/tb_counter_ctrl.sv
// Self-checking bench for counter_ctrl: directed scenarios plus random commands
// compared cycle by cycle against an integer reference model.
module tb_counter_ctrl;

    localparam int TD   = 4;
    localparam int MAXC = 9999;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_btn_run = 1'b0, i_btn_clear = 1'b0, i_btn_mode = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic [13:0] o_count;
    logic        o_run, o_mode, o_tick;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int m_count = 0, m_div = 0;
    bit m_run = 0, m_mode = 0, m_tick = 0, m_clr = 0;

    counter_ctrl #(.TICK_DIV(TD), .MAX_COUNT(MAXC)) dut (
        .clk(clk), .rst(rst),
        .i_btn_run(i_btn_run), .i_btn_clear(i_btn_clear), .i_btn_mode(i_btn_mode),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_count(o_count), .o_run(o_run), .o_mode(o_mode), .o_tick(o_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0; m_div = 0; m_run = 0; m_mode = 0; m_tick = 0; m_clr = 0;
    endtask

    // One clock of the specified behaviour, written from the command rules.
    task automatic model_step(input bit br, input bit bc, input bit bm, input bit rv, input logic [7:0] rd);
        bit run_c, clr_c, mode_c, old_mode;
        run_c  = br || (rv && (rd == "R" || rd == "r"));
        clr_c  = bc || (rv && (rd == "C" || rd == "c"));
        mode_c = bm || (rv && (rd == "M" || rd == "m"));
        m_tick = 0;
        if (m_clr) begin
            m_clr = 0; m_count = 0; m_div = 0; m_run = 0;
        end else if (clr_c) begin
            m_clr = 1; m_count = 0; m_div = 0; m_run = 0;
        end else if (run_c) begin
            m_run = !m_run;
        end else begin
            old_mode = m_mode;
            if (mode_c) m_mode = !m_mode;
            if (m_run) begin
                m_div = (m_div + 1) % TD;
                if (m_div == 0) begin
                    m_tick  = 1;
                    m_count = old_mode ? (m_count + MAXC) % (MAXC + 1) : (m_count + 1) % (MAXC + 1);
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".count"}, 32'(o_count), 32'(m_count));
        chk({tag, ".run"},   32'(o_run),   32'(m_run));
        chk({tag, ".mode"},  32'(o_mode),  32'(m_mode));
        chk({tag, ".tick"},  32'(o_tick),  32'(m_tick));
    endtask

    task automatic step(input string tag, input bit br, input bit bc, input bit bm,
                        input bit rv, input logic [7:0] rd);
        @(negedge clk);
        i_btn_run = br; i_btn_clear = bc; i_btn_mode = bm; i_rx_valid = rv; i_rx_data = rd;
        @(posedge clk);
        model_step(br, bc, bm, rv, rd);
        #1;
        check_all(tag);
        i_btn_run = 0; i_btn_clear = 0; i_btn_mode = 0; i_rx_valid = 0;
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 8'h00);
    endtask

    // Idle until the DUT ticks; an exhausted budget is a failed comparison.
    task automatic wait_tick(input string tag);
        bit seen = 0;
        for (int i = 0; i < 2 * TD && !seen; i++) begin
            idle(tag);
            seen = o_tick;
        end
        chk({tag, ".tick_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        chk({tag, ".count"}, 32'(o_count), 32'd0);
        chk({tag, ".run"},   32'(o_run),   32'd0);
        chk({tag, ".mode"},  32'(o_mode),  32'd0);
        chk({tag, ".tick"},  32'(o_tick),  32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] bytes [8];
        bytes[0] = "R"; bytes[1] = "r"; bytes[2] = "C"; bytes[3] = "c";
        bytes[4] = "M"; bytes[5] = "m"; bytes[6] = "x"; bytes[7] = 8'h00;

        // reset state
        async_reset("reset");

        // run and three ticks
        step("run_on", 1, 0, 0, 0, 8'h00);
        chk("run_on.explicit", 32'(o_run), 32'd1);
        for (int i = 0; i < 12; i++) idle("run12");
        chk("run12.count3", 32'(o_count), 32'd3);

        // clear, go down: 0 wraps to MAX; then up: MAX wraps to 0; down again
        step("clr", 0, 1, 0, 0, 8'h00);
        idle("clr_cyc");
        step("mode_dn", 0, 0, 1, 0, 8'h00);
        step("run2", 0, 0, 0, 1, "r");
        wait_tick("wrap_dn");
        chk("wrap_dn.explicit", 32'(o_count), 32'(MAXC));
        step("mode_up", 0, 0, 0, 1, "M");
        wait_tick("wrap_up");
        chk("wrap_up.explicit", 32'(o_count), 32'd0);
        step("mode_dn2", 0, 0, 1, 0, 8'h00);
        wait_tick("wrap_dn2");
        chk("wrap_dn2.explicit", 32'(o_count), 32'(MAXC));

        // double-source run command is a single toggle
        step("stop", 1, 0, 0, 0, 8'h00);
        step("dbl_run", 1, 0, 0, 1, "R");
        chk("dbl_run.explicit", 32'(o_run), 32'd1);
        step("rx_r", 0, 0, 0, 1, "r");
        chk("rx_r.explicit", 32'(o_run), 32'd0);

        // all three commands at count 37 while running up
        step("clr2", 0, 0, 0, 1, "c");
        idle("clr2_cyc");
        step("mode_up2", 0, 0, 1, 0, 8'h00);
        step("run3", 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 37; i++) wait_tick("to37");
        chk("to37.explicit", 32'(o_count), 32'd37);
        step("all3", 1, 1, 1, 0, 8'h00);
        chk("all3.count", 32'(o_count), 32'd0);
        chk("all3.mode", 32'(o_mode), 32'd0);
        step("clr_ignR", 0, 0, 0, 1, "R");
        chk("clr_ignR.run", 32'(o_run), 32'd0);
        idle("after_clr");

        // stop with divider at 2, resume continues partial period
        step("run4", 1, 0, 0, 0, 8'h00);
        idle("d1");
        idle("d2");
        step("stop_d2", 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 10; i++) idle("hold");
        step("ign_x", 0, 0, 0, 1, "x");
        step("resume", 0, 0, 0, 1, "R");
        idle("res1");
        chk("res1.no_tick", 32'(o_tick), 32'd0);
        idle("res2");
        chk("res2.tick", 32'(o_tick), 32'd1);

        // stop on a wrap cycle suppresses the tick
        idle("w1"); idle("w2"); idle("w3");
        step("stop_wrap", 1, 0, 0, 0, 8'h00);
        chk("stop_wrap.tick", 32'(o_tick), 32'd0);
        step("resume2", 1, 0, 0, 0, 8'h00);
        idle("resume2_tick");

        // random commands against the model
        for (int i = 0; i < 3000; i++) begin
            bit br, bc, bm, rv;
            br = ($urandom_range(15) == 0);
            bc = ($urandom_range(79) == 0);
            bm = ($urandom_range(15) == 0);
            rv = ($urandom_range(7) == 0);
            if ($urandom_range(999) == 0) async_reset("rnd_rst");
            else step("rnd", br, bc, bm, rv, bytes[$urandom_range(7)] ^ (($urandom_range(3) == 0) ? 8'($urandom) : 8'h00));
        end

        // reach 500 counting up, switch to down, then async reset mid-count
        step("pre_clr", 0, 1, 0, 0, 8'h00);
        idle("pre_clr_cyc");
        if (m_mode) step("pre_up", 0, 0, 1, 0, 8'h00);
        step("run5", 1, 0, 0, 0, 8'h00);
        for (int i = 0; i < 5 * TD * 500 && m_count < 500; i++) idle("to500");
        chk("to500.explicit", 32'(o_count), 32'd500);
        step("mode_dn5", 0, 0, 1, 0, 8'h00);
        chk("mode_dn5.mode", 32'(o_mode), 32'd1);
        async_reset("rst500");
        step("post_run", 1, 0, 0, 0, 8'h00);
        wait_tick("post_tick");
        chk("post_tick.explicit", 32'(o_count), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Control and datapath stage downstream of the button debouncers. It consumes single-cycle button pulses and UART receive bytes, arbitrates them into run/stop, clear and mode commands, and drives a 0–9999 up/down counter that advances on an internal tick. Its outputs feed the display/FND stage and the UART transmit path.

## Interface
- TICK_DIV, 1_000_000: clk cycles per count tick (100 Hz at 100 MHz); ≥ 2.
- MAX_COUNT, 9999: counter upper bound; wraps past it.
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- i_btn_run  input  1  one-cycle debounced pulse: toggle run/stop.
- i_btn_clear  input  1  one-cycle debounced pulse: clear counter.
- i_btn_mode  input  1  one-cycle debounced pulse: toggle up/down.
- i_rx_data  input  8  received UART byte; valid only with i_rx_valid.
- i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
- o_count  output  14  current count, 0..MAX_COUNT.
- o_run  output  1  1 = RUN state.
- o_mode  output  1  0 = count up, 1 = count down.
- o_tick  output  1  one-cycle pulse on each count update.

## Operation
- Command decode (combinational, same cycle):
  - RUN_CMD = i_btn_run or (i_rx_valid and byte is 'R' (0x52) or 'r' (0x72)).
  - CLR_CMD = i_btn_clear or (i_rx_valid and byte is 'C' (0x43) or 'c' (0x63)).
  - MODE_CMD = i_btn_mode or (i_rx_valid and byte is 'M' (0x4D) or 'm' (0x6D)).
  - Any other byte is ignored.
- Button and UART asserting the same command in one cycle count as one command; no double toggle.
- Priority when several commands fire in one cycle: CLR > RUN > MODE. Lower-priority commands in that cycle are dropped, not queued.
- FSM states: STOP (reset), RUN, CLEAR.
  - STOP: RUN_CMD -> RUN; CLR_CMD -> CLEAR.
  - RUN: RUN_CMD -> STOP; CLR_CMD -> CLEAR.
  - CLEAR: lasts exactly one cycle. It zeroes o_count and the tick divider, then goes to STOP unconditionally. Commands arriving in this cycle are ignored.
- MODE_CMD toggles o_mode in STOP or RUN. The run state is unchanged.
- Tick divider:
  - Counts only in RUN.
  - Holds its value in STOP, so resuming continues the partial period.
  - When it reaches TICK_DIV-1 it returns to 0 and o_tick is asserted.
- Count update on tick:
  - Up mode: MAX_COUNT wraps to 0, otherwise count+1.
  - Down mode: 0 wraps to MAX_COUNT, otherwise count-1.
- Counter arithmetic is 14-bit unsigned. Divider width is $clog2(TICK_DIV).

## Timing
- Reset values: o_count=0, o_run=0, o_mode=0, o_tick=0, state STOP, divider 0. Reset asserted mid-operation forces these immediately, independent of clk.
- A command sampled at edge n is reflected in o_run/o_mode after edge n; latency is 1 cycle.
- o_tick is registered and high for exactly one cycle. o_count takes its new value on the same edge that raises o_tick.
- In RUN with no commands, ticks occur every TICK_DIV cycles. The first tick after entering RUN from a zeroed divider arrives TICK_DIV cycles after the RUN transition edge.
- RUN_CMD (stop) on the same cycle the divider would wrap: the tick is suppressed and the divider holds at TICK_DIV-1.
- MODE_CMD on a tick cycle: the tick uses the old mode. The new mode applies from the next tick.
- CLR_CMD on a tick cycle: clear wins; o_count=0 and o_tick=0.

## Test plan
- Reset, then RUN with TICK_DIV=4 and 12 cycles of no command -> o_run=1 one cycle after the pulse; o_tick pulses every 4 cycles; o_count = 1, 2, 3.
- o_count=9999, up mode, tick -> o_count=0. Then MODE_CMD and a tick -> o_count=9999.
- i_btn_run and i_rx_data='R' with valid in the same cycle from STOP -> o_run=1 (single toggle). A following 'r' byte -> o_run=0.
- CLR_CMD, RUN_CMD and MODE_CMD together while running at count 37 -> next cycle o_count=0 and state CLEAR; o_run=0 thereafter; o_mode unchanged; a 'R' byte in the CLEAR cycle is ignored.
- Stop at divider=2, wait 10 cycles, restart -> next tick after 2 RUN cycles; byte 'x' (0x78) with valid causes no change.
- Assert rst asynchronously mid-count at 500 in down mode -> all outputs zero before the next clk edge; normal operation resumes after release.
